// File: rtl/dump_seq_ctrl.sv
// dump_seq_ctrl: programs the dump generator once per start, then runs rep trains with a reset gap; outputs registered (1-cycle).
// No backpressure; abort wins everywhere. Optional run watchdog under `DUMP_SEQ_TIMEOUT_EN` (err tied 0 otherwise).
module dump_seq_ctrl #(
  parameter int TO_W  = 16,
  parameter int GAP_W = 16
) (
  input  logic        clkin,
  input  logic        reset,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_addr,
  input  logic [15:0] cfg_data,
  input  logic        start,
  input  logic        abort,
  input  logic        dump_over,
  output logic        dump_load,
  output logic [1:0]  dump_choice,
  output logic [15:0] dump_data,
  output logic        dump_rst,
  output logic        busy,
  output logic        done,
  output logic        err
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PROG = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [2:0]       step_q, step_d;
  logic [11:0]      one_dump_q, one_dump_d;
  logic [11:0]      w_time_q, w_time_d;
  logic [11:0]      l_dump_q, l_dump_d;
  logic [7:0]       rep_cnt_q, rep_cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [7:0]       rep_left_q, rep_left_d;
  logic [GAP_W-1:0] gap_left_q, gap_left_d;
  logic             load_q, load_d;
  logic [1:0]       choice_q, choice_d;
  logic [15:0]      data_q, data_d;
  logic             rst_q, rst_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [11:0]      prog_val;
`ifdef DUMP_SEQ_TIMEOUT_EN
  logic [TO_W-1:0]  wd_q, wd_d;
`endif

  // Even steps set up choice/data, odd steps strobe load; step pair index selects the register.
  always_comb begin
    case (step_q[2:1])
      2'd0:    prog_val = one_dump_q;
      2'd1:    prog_val = w_time_q;
      default: prog_val = l_dump_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    one_dump_d = one_dump_q;
    w_time_d   = w_time_q;
    l_dump_d   = l_dump_q;
    rep_cnt_d  = rep_cnt_q;
    gap_d      = gap_q;
    rep_left_d = rep_left_q;
    gap_left_d = gap_left_q;
    load_d     = 1'b0;
    choice_d   = choice_q;
    data_d     = data_q;
    rst_d      = rst_q;
    done_d     = 1'b0;
    err_d      = err_q;
`ifdef DUMP_SEQ_TIMEOUT_EN
    wd_d       = wd_q;
`endif

    if (cfg_we && !busy_q) begin
      case (cfg_addr)
        3'd0:    one_dump_d = cfg_data[11:0];
        3'd1:    w_time_d   = cfg_data[11:0];
        3'd2:    l_dump_d   = cfg_data[11:0];
        3'd3:    rep_cnt_d  = cfg_data[7:0];
        3'd4:    gap_d      = cfg_data[GAP_W-1:0];
        default: ;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        rst_d = 1'b1;
        if (start && !abort) begin
          state_d    = S_PROG;
          step_d     = 3'd0;
          err_d      = 1'b0;
          rep_left_d = (rep_cnt_d == 8'd0) ? 8'd1 : rep_cnt_d;
        end
      end
      S_PROG: begin
        step_d = step_q + 3'd1;
        if (step_q == 3'd6) begin
          state_d = S_RUN;
          rst_d   = 1'b0;
`ifdef DUMP_SEQ_TIMEOUT_EN
          wd_d    = '0;
`endif
        end else if (!step_q[0]) begin
          choice_d = step_q[2:1];
          data_d   = {4'b0000, prog_val};
        end else begin
          load_d = 1'b1;
        end
      end
      S_RUN: begin
        if (!dump_over) begin
          state_d    = S_GAP;
          rst_d      = 1'b1;
          rep_left_d = rep_left_q - 8'd1;
          gap_left_d = (gap_q == '0) ? '0 : gap_q - 1'b1;
        end
`ifdef DUMP_SEQ_TIMEOUT_EN
        else if (wd_q == {{(TO_W-1){1'b1}}, 1'b0}) begin
          state_d = S_DONE;
          rst_d   = 1'b1;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      S_GAP: begin
        if (gap_left_q == '0) begin
          if (rep_left_q != 8'd0) begin
            state_d = S_RUN;
            rst_d   = 1'b0;
`ifdef DUMP_SEQ_TIMEOUT_EN
            wd_d    = '0;
`endif
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end else begin
          gap_left_d = gap_left_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        rst_d   = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        rst_d   = 1'b1;
      end
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      rst_d   = 1'b1;
      load_d  = 1'b0;
      done_d  = 1'b0;
      err_d   = err_q;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q    <= S_IDLE;
      step_q     <= 3'd0;
      one_dump_q <= 12'd0;
      w_time_q   <= 12'd0;
      l_dump_q   <= 12'd0;
      rep_cnt_q  <= 8'd1;
      gap_q      <= '0;
      rep_left_q <= 8'd0;
      gap_left_q <= '0;
      load_q     <= 1'b0;
      choice_q   <= 2'd0;
      data_q     <= 16'd0;
      rst_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef DUMP_SEQ_TIMEOUT_EN
      wd_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      one_dump_q <= one_dump_d;
      w_time_q   <= w_time_d;
      l_dump_q   <= l_dump_d;
      rep_cnt_q  <= rep_cnt_d;
      gap_q      <= gap_d;
      rep_left_q <= rep_left_d;
      gap_left_q <= gap_left_d;
      load_q     <= load_d;
      choice_q   <= choice_d;
      data_q     <= data_d;
      rst_q      <= rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef DUMP_SEQ_TIMEOUT_EN
      wd_q       <= wd_d;
`endif
    end
  end

  assign dump_load   = load_q;
  assign dump_choice = choice_q;
  assign dump_data   = data_q;
  assign dump_rst    = rst_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
endmodule

// File: tb/tb_dump_seq_ctrl.sv
// Scoreboard bench for dump_seq_ctrl: expected generator-port events are queued per start, a monitor pops them.
module tb_dump_seq_ctrl;
  logic        clkin = 1'b0;
  logic        reset, cfg_we, start, abort, dump_over;
  logic [2:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic        dump_load, dump_rst, busy, done, err;
  logic [1:0]  dump_choice;
  logic [15:0] dump_data;

  always #5 clkin = ~clkin;

  dump_seq_ctrl #(.TO_W(4), .GAP_W(16)) dut (
    .clkin(clkin), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .abort(abort), .dump_over(dump_over), .dump_load(dump_load),
    .dump_choice(dump_choice), .dump_data(dump_data), .dump_rst(dump_rst),
    .busy(busy), .done(done), .err(err)
  );

  localparam int EV_LOAD = 0, EV_RSTART = 1, EV_RUN = 2, EV_GAP = 3, EV_DONE = 4;
  typedef struct { int k; int a; int b; } ev_t;
  ev_t exp_q[$];

  int total = 0, bad = 0;
  int ncyc = 0, st_n = 0, gen_len = 8;
  bit mon_en = 1'b0;
  int m_one, m_w, m_l, m_rep, m_gap;

  function automatic void check(string nm, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endfunction

  function automatic void push(int k, int a, int b);
    ev_t e;
    e.k = k; e.a = a; e.b = b;
    exp_q.push_back(e);
  endfunction

  function automatic void mon_ev(int k, int a, int b);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: got kind=%0d a=%0h b=%0h want none", k, a, b);
    end else begin
      e = exp_q.pop_front();
      if (e.k != k || e.a != a || e.b != b) begin
        bad++;
        $display("FAIL event: got kind=%0d a=%0h b=%0h want kind=%0d a=%0h b=%0h", k, a, b, e.k, e.a, e.b);
      end
    end
  endfunction

  // Reference config model: register widths and reset values, writes only while idle.
  function automatic void model_wr(int a, logic [15:0] d);
    case (a)
      0: m_one = int'(d[11:0]);
      1: m_w   = int'(d[11:0]);
      2: m_l   = int'(d[11:0]);
      3: m_rep = int'(d[7:0]);
      4: m_gap = int'(d);
      default: ;
    endcase
  endfunction

  function automatic void model_reset();
    m_one = 0; m_w = 0; m_l = 0; m_rep = 1; m_gap = 0;
  endfunction

  function automatic void push_prog();
    push(EV_LOAD, 0, m_one);
    push(EV_LOAD, 1, m_w);
    push(EV_LOAD, 2, m_l);
    push(EV_RSTART, 8, 0);
  endfunction

  function automatic void push_train(int len);
    int reps;
    reps = (m_rep == 0) ? 1 : m_rep;
    push_prog();
    for (int r = 0; r < reps; r++) begin
      push(EV_RUN, len, 0);
      push(EV_GAP, (m_gap == 0) ? 1 : m_gap, 0);
    end
    push(EV_DONE, 0, 0);
  endfunction

  // Generator stand-in: over stays high for gen_len cycles after its reset is released.
  initial begin
    int cnt;
    cnt = 0;
    dump_over = 1'b1;
    forever begin
      @(negedge clkin);
      if (dump_rst) cnt = 0;
      else cnt++;
      dump_over = (cnt < gen_len);
    end
  end

  // Monitor: turns the generator-side waveform into events and scores them.
  initial begin
    logic       p_load, p_rst;
    logic [1:0] p_ch;
    logic [15:0] p_dat;
    int rcnt, gcnt;
    bit in_train;
    p_load = 1'b0; p_rst = 1'b1; p_ch = 2'd0; p_dat = 16'd0;
    rcnt = 0; gcnt = 0; in_train = 1'b0;
    forever begin
      @(negedge clkin);
      ncyc++;
      if (mon_en) begin
        if (dump_load && !p_load) begin
          mon_ev(EV_LOAD, int'(dump_choice), int'(dump_data));
          check("load_setup", {14'd0, p_ch, p_dat}, {14'd0, dump_choice, dump_data});
        end
        if (!busy) begin
          in_train = 1'b0;
          gcnt = 0;
        end else begin
          if (!dump_rst && p_rst) begin
            if (!in_train) begin
              mon_ev(EV_RSTART, ncyc - st_n, 0);
              in_train = 1'b1;
            end else begin
              mon_ev(EV_GAP, gcnt, 0);
            end
            rcnt = 1;
            gcnt = 0;
          end else if (!dump_rst) begin
            rcnt++;
          end else if (!p_rst) begin
            mon_ev(EV_RUN, rcnt, 0);
            gcnt = done ? 0 : 1;
          end else if (in_train && !done) begin
            gcnt++;
          end
          if (done) begin
            if (in_train && gcnt > 0) mon_ev(EV_GAP, gcnt, 0);
            mon_ev(EV_DONE, 0, 0);
            in_train = 1'b0;
            gcnt = 0;
          end
        end
      end
      p_load = dump_load; p_rst = dump_rst; p_ch = dump_choice; p_dat = dump_data;
    end
  end

  task automatic tick();
    @(negedge clkin);
    #1;
  endtask

  task automatic cfg_wr(int a, logic [15:0] d, bit accepted);
    cfg_we = 1'b1;
    cfg_addr = a[2:0];
    cfg_data = d;
    tick();
    cfg_we = 1'b0;
    if (accepted) model_wr(a, d);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    st_n = ncyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_drain(string nm, int bound);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < bound) begin
      tick();
      n++;
    end
    check({nm, "_drain"}, 32'(n < bound), 32'd1);
    if (n >= bound) exp_q.delete();
  endtask

  task automatic run_train(int len, string nm);
    gen_len = len;
    push_train(len);
    pulse_start();
    wait_drain(nm, 3000);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1; cfg_we = 1'b0; cfg_addr = 3'd0; cfg_data = 16'd0; start = 1'b0; abort = 1'b0;
    model_reset();
    tick(); tick();
    check("rst_load", 32'(dump_load), 32'd0);
    check("rst_choice", 32'(dump_choice), 32'd0);
    check("rst_data", 32'(dump_data), 32'd0);
    check("rst_dump_rst", 32'(dump_rst), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    reset = 1'b0;
    mon_en = 1'b1;
    tick();

    cfg_wr(0, 16'h0010, 1); cfg_wr(1, 16'h0004, 1); cfg_wr(2, 16'h0030, 1);
    cfg_wr(3, 16'h0001, 1); cfg_wr(4, 16'h0000, 1);
    run_train(48, "basic");

    cfg_wr(3, 16'h0003, 1); cfg_wr(4, 16'h0005, 1);
    run_train(7, "rep3_gap5");

    // Abort during the second run window.
    cfg_wr(4, 16'h0002, 1);
    gen_len = 6;
    push_prog();
    push(EV_RUN, 6, 0);
    push(EV_GAP, 2, 0);
    pulse_start();
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin tick(); n++; end
    check("abort_reach_run2", 32'(n < 500), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_dump_rst", 32'(dump_rst), 32'd1);
    check("abort_done", 32'(done), 32'd0);
    check("abort_load", 32'(dump_load), 32'd0);
    repeat (20) tick();
    check("abort_stays_idle", 32'(busy), 32'd0);

    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    tick();
    check("start_abort_idle", 32'(busy), 32'd0);
    check("start_abort_rst", 32'(dump_rst), 32'd1);

    // Config write while busy must not land.
    gen_len = 10;
    push_train(10);
    pulse_start();
    repeat (4) tick();
    cfg_wr(0, 16'h0ABC, 0);
    wait_drain("busy_wr", 3000);
    cfg_wr(3, 16'h0001, 1);
    cfg_wr(6, 16'hFFFF, 1);
    run_train(5, "after_busy_wr");

    // Write coinciding with the accepted start is used for programming.
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 16'hF123;
    model_wr(0, 16'hF123);
    gen_len = 4;
    push_train(4);
    start = 1'b1;
    st_n = ncyc;
    tick();
    cfg_we = 1'b0; start = 1'b0;
    wait_drain("same_cycle_wr", 3000);

    for (int it = 0; it < 6; it++) begin
      cfg_wr(0, 16'($urandom), 1);
      cfg_wr(1, 16'($urandom), 1);
      cfg_wr(2, 16'($urandom), 1);
      cfg_wr(3, (16'($urandom) & 16'hFF00) | 16'($urandom_range(0, 3)), 1);
      cfg_wr(4, 16'($urandom_range(0, 4)), 1);
      cfg_wr(5 + int'($urandom_range(0, 2)), 16'($urandom), 1);
      run_train(int'($urandom_range(1, 12)), "rand");
    end

`ifdef DUMP_SEQ_TIMEOUT_EN
    cfg_wr(3, 16'h0002, 1);
    gen_len = 100000;
    push_prog();
    push(EV_RUN, 15, 0);
    push(EV_DONE, 0, 0);
    pulse_start();
    wait_drain("timeout", 500);
    check("timeout_err", 32'(err), 32'd1);
    gen_len = 3;
    push_train(3);
    pulse_start();
    check("err_cleared", 32'(err), 32'd0);
    wait_drain("after_timeout", 3000);
`else
    check("err_tied", 32'(err), 32'd0);
`endif

    // Reset in the middle of programming.
    cfg_wr(3, 16'h0003, 1); cfg_wr(0, 16'h0555, 1);
    mon_en = 1'b0;
    gen_len = 5;
    pulse_start();
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_load", 32'(dump_load), 32'd0);
    check("midrst_dump_rst", 32'(dump_rst), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_choice", 32'(dump_choice), 32'd0);
    check("midrst_data", 32'(dump_data), 32'd0);
    model_reset();
    exp_q.delete();
    tick();
    mon_en = 1'b1;
    run_train(5, "post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dump_seq_ctrl.md
# dump_seq_ctrl

Sequencer for the dump timing generator in the NMR FPGA. It holds the host-written dump configuration and programs the generator through its `load`/`choice`/`datain` port. It then releases the generator's reset to run one dump train and waits for the generator's `over` flag to fall. It repeats the train a programmed number of times with a programmable gap, and reports completion, abort and watchdog errors to the host control logic.

## Interface
Parameters:
- `TO_W`, 16: width of the run watchdog counter; timeout = 2^TO_W−1 cycles.
- `GAP_W`, 16: width of the inter-train gap register/counter.

Ports:
- `clkin` in 1: system clock. All logic on the rising edge.
- `reset` in 1: reset is synchronous and active-high.
- `cfg_we` in 1: config write strobe. Ignored while `busy`=1.
- `cfg_addr` in 3: 0=one_dump[11:0], 1=w_time[11:0], 2=l_dump[11:0], 3=rep_cnt[7:0], 4=gap[GAP_W-1:0]. Writes to 5–7 are ignored.
- `cfg_data` in 16: write data. Low bits used per register; upper bits discarded.
- `start` in 1: one-cycle start request. Ignored unless the FSM is in IDLE.
- `abort` in 1: stop request. Honoured in any state. Wins over `start`.
- `dump_over` in 1: generator `over` (1 = not finished, 0 = train finished).
- `dump_load` out 1: generator load strobe. Edge-sensitive at the generator.
- `dump_choice` out 2: generator register select.
- `dump_data` out 16: generator data, {4'b0, reg[11:0]}.
- `dump_rst` out 1: generator reset. 1 holds the generator idle.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at normal or timeout completion.
- `err` out 1: sticky watchdog error. Cleared on accepted `start`.

## Operation
- Reset values:
  - Outputs: dump_load=0, dump_choice=0, dump_data=0, dump_rst=1, busy=0, done=0, err=0.
  - Registers: one_dump=0, w_time=0, l_dump=0, rep_cnt=1, gap=0.
  - FSM in IDLE.
- All outputs are registered.
- IDLE:
  - dump_rst=1.
  - `start`=1 and `abort`=0 → PROG. Clear err. Load the rep counter with rep_cnt; rep_cnt=0 is treated as 1.
- PROG: six cycles, programming three generator registers in order:
  - choice 0 = one_dump, choice 1 = w_time, choice 2 = l_dump.
  - For each register, `dump_choice`/`dump_data` are driven in a setup cycle. They are held with `dump_load`=1 in the following cycle.
  - `dump_load` returns to 0 between writes.
  - Programming is done once per `start`, not once per train.
- RUN:
  - dump_rst=0. The watchdog counter is cleared on entry.
  - `dump_over`=0 is sampled → GAP. Decrement the rep counter.
- GAP:
  - dump_rst=1.
  - Lasts max(gap,1) cycles, so the generator always sees at least one reset cycle.
  - At the end: rep counter ≠0 → RUN; otherwise → DONE.
- DONE: done=1 for one cycle, dump_rst=1 → IDLE.
- Abort:
  - In any non-IDLE state → IDLE on the next edge, with dump_rst=1 and dump_load=0.
  - No `done` pulse. err is unchanged.
- `dump_choice`/`dump_data` keep their last value outside PROG. `dump_choice`=3 is never driven.

## Timing
- `start` sampled at edge E0.
- `dump_load`=1 in the cycles after E2, E4 and E6. Choice/data are stable from the cycles after E1, E3 and E5 through each load cycle.
- `dump_rst` falls in the cycle after E7 (first RUN cycle).
- `dump_over` low sampled at edge Ek → `dump_rst`=1 in the cycle after Ek.
- Final GAP ends at edge Eg → `done`=1 and `busy`=1 in the cycle after Eg. `busy` falls one cycle later.
- `reset` mid-operation: next cycle all outputs return to their reset values. Config registers are reinitialised.
- `cfg_we` in the same cycle as an accepted `start`: the write takes effect and is used for programming.

## Configuration
- Macro `DUMP_SEQ_TIMEOUT_EN`.
- Defined:
  - In RUN, the watchdog counts cycles.
  - Reaching 2^TO_W−1 without `dump_over`=0 → err=1, DONE (done pulses), remaining reps dropped.
- Undefined:
  - No watchdog logic. RUN waits indefinitely.
  - `err` is tied 0.

## Test plan
- Write one_dump=0x010, w_time=0x004, l_dump=0x030, rep=1, gap=0, then `start` → three load pulses with (choice,data) = (0,0x0010), (1,0x0004), (2,0x0030). dump_rst low from cycle 8. Model drops `over` after 48 cycles → one GAP cycle, then done pulse.
- rep=3, gap=5 → three RUN windows, each followed by exactly 5 dump_rst-high cycles. Exactly 3 programming writes total. One done pulse.
- `abort` in the 2nd RUN of rep=3 → IDLE next cycle, dump_rst=1, busy=0, no done.
- `start`+`abort` same cycle in IDLE → stays IDLE. `cfg_we` while busy → register unchanged after completion.
- With `DUMP_SEQ_TIMEOUT_EN`, TO_W=4, `dump_over` held 1 → err=1 and done after 15 RUN cycles. The next `start` clears err.
- `reset` asserted during PROG → next cycle dump_load=0, dump_rst=1, rep_cnt reads back as 1 behaviour (single train on next `start`).
